// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side is the datapath and the slave side is the scheduler.
interface pipe_hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       mdu_use_D;
    logic [4:0] WriteReg_E;
    logic       RegWrite_E;
    logic [1:0] tnew_E;
    logic [4:0] WriteReg_M;
    logic       RegWrite_M;
    logic [1:0] tnew_M;
    logic       mdu_start_E;
    logic       mdu_is_div_E;
    logic       pc_en;
    logic       fd_en;
    logic       de_flush;
    logic       em_en;
    logic       mw_en;
    logic       mdu_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, mdu_use_D,
        output WriteReg_E, RegWrite_E, tnew_E,
        output WriteReg_M, RegWrite_M, tnew_M,
        output mdu_start_E, mdu_is_div_E,
        input  pc_en, fd_en, de_flush, em_en, mw_en, mdu_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, mdu_use_D,
        input  WriteReg_E, RegWrite_E, tnew_E,
        input  WriteReg_M, RegWrite_M, tnew_M,
        input  mdu_start_E, mdu_is_div_E,
        output pc_en, fd_en, de_flush, em_en, mw_en, mdu_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (Tuse/Tnew + MDU busy timer).
// Optional stall counters are enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       mdu_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] LP_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LP_DIV  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] r_busy_cnt;
    logic             w_busy;
    logic             w_rs_e;
    logic             w_rs_m;
    logic             w_rt_e;
    logic             w_rt_m;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_mdu;
    logic             w_stall;

    // Tnew = 0 or Tuse = 3 can never satisfy tuse < tnew, so neither stalls.
    assign w_rs_e = hz.RegWrite_E && (hz.rs_D == hz.WriteReg_E)
                    && (hz.tuse_rs_D < hz.tnew_E);
    assign w_rs_m = hz.RegWrite_M && (hz.rs_D == hz.WriteReg_M)
                    && (hz.tuse_rs_D < hz.tnew_M);
    assign w_rt_e = hz.RegWrite_E && (hz.rt_D == hz.WriteReg_E)
                    && (hz.tuse_rt_D < hz.tnew_E);
    assign w_rt_m = hz.RegWrite_M && (hz.rt_D == hz.WriteReg_M)
                    && (hz.tuse_rt_D < hz.tnew_M);

    assign w_stall_rs  = (hz.rs_D != 5'd0) && (w_rs_e || w_rs_m);
    assign w_stall_rt  = (hz.rt_D != 5'd0) && (w_rt_e || w_rt_m);
    assign w_busy      = (r_busy_cnt != '0);
    assign w_stall_mdu = hz.mdu_use_D && (hz.mdu_start_E || w_busy);
    assign w_stall     = w_stall_rs | w_stall_rt | w_stall_mdu;

    assign hz.pc_en    = ~w_stall;
    assign hz.fd_en    = ~w_stall;
    assign hz.de_flush = w_stall;
    assign hz.em_en    = 1'b1;
    assign hz.mw_en    = 1'b1;
    assign hz.mdu_busy = w_busy;

    // A new start always reloads, even while a previous op is still running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt <= '0;
        end else if (hz.mdu_start_E) begin
            r_busy_cnt <= hz.mdu_is_div_E ? LP_DIV : LP_MULT;
        end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_mdu_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles     <= '0;
            r_mdu_stall_cycles <= '0;
        end else begin
            if (w_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_stall_mdu)
                r_mdu_stall_cycles <= r_mdu_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles     = r_stall_cycles;
    assign mdu_stall_cycles = r_mdu_stall_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors queue
// expected outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] mdu_stall_cycles;
`endif

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .hz               (hz.slave)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .mdu_stall_cycles (mdu_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  exp;
        logic [31:0] sc;
        logic [31:0] msc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_sc  = 0;
    logic [31:0] m_msc = 0;

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {hz.pc_en, hz.fd_en, hz.de_flush,
                   hz.em_en, hz.mw_en, hz.mdu_busy};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got pc/fd/flush/em/mw/busy=%b want %b",
                         e.name, act, e.exp);
            end
`ifdef HAZARD_STALL_CNT_EN
            checks++;
            if (stall_cycles !== e.sc || mdu_stall_cycles !== e.msc) begin
                errors++;
                $display("FAIL %s_cnt: got %0d/%0d want %0d/%0d", e.name,
                         stall_cycles, mdu_stall_cycles, e.sc, e.msc);
            end
`endif
        end
    end

    // Queue the expectation for the current input set, then advance a cycle.
    task automatic cyc(input string nm, input bit s, input bit smdu,
                       input bit busy);
        exp_t e;
        e.name = nm;
        e.exp  = {~s, ~s, s, 1'b1, 1'b1, busy};
        e.sc   = m_sc;
        e.msc  = m_msc;
        q.push_back(e);
        @(posedge clk);
        if (reset) begin
            m_sc  = 0;
            m_msc = 0;
        end else begin
            if (s)    m_sc  = m_sc + 1;
            if (smdu) m_msc = m_msc + 1;
        end
        #1;
    endtask

    task automatic idle();
        hz.rs_D = 0; hz.rt_D = 0;
        hz.tuse_rs_D = 3; hz.tuse_rt_D = 3;
        hz.mdu_use_D = 0;
        hz.WriteReg_E = 0; hz.RegWrite_E = 0; hz.tnew_E = 0;
        hz.WriteReg_M = 0; hz.RegWrite_M = 0; hz.tnew_M = 0;
        hz.mdu_start_E = 0; hz.mdu_is_div_E = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        cyc("reset", 0, 0, 0);
        reset = 1'b0;

        // load-use on rs from E, then the same producer in M
        hz.WriteReg_E = 8; hz.RegWrite_E = 1; hz.tnew_E = 2;
        hz.rs_D = 8; hz.tuse_rs_D = 0;
        cyc("lu_E", 1, 0, 0);
        hz.RegWrite_E = 0;
        hz.WriteReg_M = 8; hz.RegWrite_M = 1; hz.tnew_M = 1;
        cyc("lu_M1", 1, 0, 0);
        hz.tnew_M = 0;
        cyc("lu_M0", 0, 0, 0);

        idle();
        hz.WriteReg_E = 0; hz.RegWrite_E = 1; hz.tnew_E = 2;
        hz.rs_D = 0; hz.tuse_rs_D = 0;
        cyc("reg0", 0, 0, 0);
        hz.WriteReg_E = 8; hz.rs_D = 8;
        hz.tuse_rs_D = 1; hz.tnew_E = 1;
        cyc("tuse_eq_tnew", 0, 0, 0);
        hz.RegWrite_E = 0; hz.tnew_E = 2; hz.tuse_rs_D = 0;
        cyc("no_regwrite", 0, 0, 0);

        idle();
        hz.WriteReg_E = 9; hz.RegWrite_E = 1; hz.tnew_E = 2;
        hz.rt_D = 9; hz.tuse_rt_D = 1;
        cyc("rt_E", 1, 0, 0);

        // mult with D-stage MDU use held throughout
        idle();
        hz.mdu_use_D = 1;
        hz.mdu_start_E = 1; hz.mdu_is_div_E = 0;
        cyc("mult_c0", 1, 1, 0);
        hz.mdu_start_E = 0;
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("mult_c%0d", i), 1, 1, 1);
        cyc("mult_c6", 0, 0, 0);

        // div without MDU use: busy only, never stalls
        idle();
        hz.mdu_start_E = 1; hz.mdu_is_div_E = 1;
        cyc("div_c0", 0, 0, 0);
        hz.mdu_start_E = 0;
        for (int i = 1; i <= 10; i++)
            cyc($sformatf("div_c%0d", i), 0, 0, 1);
        cyc("div_c11", 0, 0, 0);

        // restart: div at c0, mult at c3
        hz.mdu_start_E = 1; hz.mdu_is_div_E = 1;
        cyc("rs_c0", 0, 0, 0);
        hz.mdu_start_E = 0;
        cyc("rs_c1", 0, 0, 1);
        cyc("rs_c2", 0, 0, 1);
        hz.mdu_start_E = 1; hz.mdu_is_div_E = 0;
        cyc("rs_c3", 0, 0, 1);
        hz.mdu_start_E = 0;
        for (int i = 4; i <= 8; i++)
            cyc($sformatf("rs_c%0d", i), 0, 0, 1);
        cyc("rs_c9", 0, 0, 0);

        // reset in the middle of a div
        hz.mdu_start_E = 1; hz.mdu_is_div_E = 1;
        cyc("rst_c0", 0, 0, 0);
        hz.mdu_start_E = 0;
        for (int i = 1; i <= 3; i++)
            cyc($sformatf("rst_c%0d", i), 0, 0, 1);
        reset = 1'b1;
        cyc("rst_c4", 0, 0, 1);
        reset = 1'b0;
        hz.mdu_use_D = 1;
        cyc("rst_c5", 0, 0, 0);
        cyc("rst_c6", 0, 0, 0);
        idle();

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            $display("FAIL drain: %0d entries left want 0", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
